// File: rtl/flag_pkg.sv
// Shared definitions for the flag/condition unit: flag bit positions,
// condition-code selectors, FSM encodings and the condition evaluator.
package flag_pkg;

  localparam int unsigned FLG_W  = 5;
  localparam int unsigned COND_W = 4;

  localparam int unsigned FLG_S = 4;
  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_P = 1;
  localparam int unsigned FLG_V = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_PE = 4'hE;
  localparam logic [COND_W-1:0] COND_AL = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_e;

  // Evaluate one condition code against a flag word {S,C,Z,P,V}.
  function automatic logic cond_eval(input logic [COND_W-1:0] code,
                                     input logic [FLG_W-1:0]  f);
    logic s, c, z, p, v, r;
    s = f[FLG_S];
    c = f[FLG_C];
    z = f[FLG_Z];
    p = f[FLG_P];
    v = f[FLG_V];
    case (code)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = s;
      COND_PL: r = ~s;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = s ~^ v;
      COND_LT: r = s ^ v;
      COND_GT: r = ~z & (s ~^ v);
      COND_LE: r = z | (s ^ v);
      COND_PE: r = p;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO save/restore stack for the flag register, with full/empty status
// and a one-cycle error pulse on illegal or conflicting operations.
module flag_stack
  import flag_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned SP_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [FLG_W-1:0] f_in,
  output logic             pop_ok_c,
  output logic [FLG_W-1:0] top_c,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int unsigned SPW1 = SP_W + 1;

  logic [FLG_W-1:0] mem_q [STK_DEPTH];
  logic [FLG_W-1:0] mem_d [STK_DEPTH];
  logic [SPW1-1:0]  sp_q, sp_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;
  logic             push_ok;
  logic [SP_W-1:0]  wr_idx;
  logic [SP_W-1:0]  rd_idx;

  assign wr_idx   = sp_q[SP_W-1:0];
  assign rd_idx   = SP_W'(sp_q - SPW1'(1));
  assign push_ok  = push & ~pop & ~full_q;
  assign pop_ok_c = pop & ~push & ~empty_q;
  assign top_c    = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push_ok) begin
      mem_d[wr_idx] = f_in;
      sp_d          = sp_q + SPW1'(1);
    end else if (pop_ok_c) begin
      sp_d = sp_q - SPW1'(1);
    end
    full_d  = (sp_d == SPW1'(STK_DEPTH));
    empty_d = (sp_d == '0);
    err_d   = (push & pop) | (push & ~pop & full_q) | (pop & ~push & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STK_DEPTH); i++) mem_q[i] <= '0;
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule

// File: rtl/flag_cond_unit.sv
// Flag status register with save/restore stack and a two-state condition
// evaluator producing a registered take result one cycle after acceptance.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned SP_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flg_we,
  input  logic              sign_in,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              parity_in,
  input  logic              overflow_in,
  input  logic              push,
  input  logic              pop,
  input  logic              cond_valid,
  input  logic [COND_W-1:0] cond_code,
  output logic              cond_ready,
  output logic              take_valid,
  output logic              take,
  output logic [FLG_W-1:0]  flags_out,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  logic [FLG_W-1:0] f_q, f_d;
  state_e           state_q, state_d;
  logic             take_q, take_d;
  logic             take_valid_q, take_valid_d;
  logic             accept_c;
  logic             pop_ok_c;
  logic [FLG_W-1:0] top_c;

  flag_stack #(
    .STK_DEPTH(STK_DEPTH),
    .SP_W     (SP_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .f_in    (f_q),
    .pop_ok_c(pop_ok_c),
    .top_c   (top_c),
    .full    (stk_full),
    .empty   (stk_empty),
    .err     (stk_err)
  );

  // Restore from stack outranks a fresh ALU load.
  always_comb begin
    f_d = f_q;
    if (pop_ok_c) f_d = top_c;
    else if (flg_we) f_d = {sign_in, carry_in, zero_in, parity_in, overflow_in};
  end

  // Result uses F before this edge's update, so same-cycle flg_we is not seen.
  always_comb begin
    state_d      = state_q;
    take_d       = take_q;
    take_valid_d = 1'b0;
    accept_c     = cond_valid & (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d      = EVAL;
          take_d       = cond_eval(cond_code, f_q);
          take_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q          <= '0;
      state_q      <= IDLE;
      take_q       <= 1'b0;
      take_valid_q <= 1'b0;
    end else begin
      f_q          <= f_d;
      state_q      <= state_d;
      take_q       <= take_d;
      take_valid_q <= take_valid_d;
    end
  end

  assign cond_ready = (state_q == IDLE);
  assign take_valid = take_valid_q;
  assign take       = take_q;
  assign flags_out  = f_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed scoreboard bench for flag_cond_unit: condition results are queued
// at issue and checked by a forked monitor whenever take_valid is seen.
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flg_we, sign_in, carry_in, zero_in, parity_in, overflow_in;
  logic       push, pop, cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready, take_valid, take, stk_full, stk_empty, stk_err;
  logic [4:0] flags_out;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  flag_cond_unit #(.STK_DEPTH(4), .SP_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flg_we     (flg_we),
    .sign_in    (sign_in),
    .carry_in   (carry_in),
    .zero_in    (zero_in),
    .parity_in  (parity_in),
    .overflow_in(overflow_in),
    .push       (push),
    .pop        (pop),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_ready (cond_ready),
    .take_valid (take_valid),
    .take       (take),
    .flags_out  (flags_out),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_flags(input logic [4:0] f);
    {sign_in, carry_in, zero_in, parity_in, overflow_in} = f;
  endtask

  task automatic set_flags(input logic [4:0] f);
    flg_we = 1'b1;
    drive_flags(f);
    tick();
    flg_we = 1'b0;
  endtask

  // Issue one request, wait for the EVAL cycle to pass.
  task automatic req(input logic [3:0] code, input bit exp);
    int n = 0;
    while (!cond_ready && n < 10) begin
      tick();
      n++;
    end
    if (!cond_ready) check("req_ready_timeout", 8'(cond_ready), 8'd1);
    cond_valid = 1'b1;
    cond_code  = code;
    exp_q.push_back(exp);
    tick();
    cond_valid = 1'b0;
    tick();
  endtask

  task automatic do_op(input logic p_push, input logic p_pop, input logic we, input logic [4:0] f);
    push   = p_push;
    pop    = p_pop;
    flg_we = we;
    drive_flags(f);
    tick();
    push   = 1'b0;
    pop    = 1'b0;
    flg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flg_we = 1'b0; push = 1'b0; pop = 1'b0; cond_valid = 1'b0; cond_code = 4'h0;
    drive_flags(5'h00);

    fork
      forever begin
        @(negedge clk);
        if (!rst && take_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_take_valid", 8'd1, 8'd0);
          end else begin
            bit e;
            e = exp_q.pop_front();
            check("take", 8'(take), 8'(e));
          end
        end
      end
    join_none

    // Ops toggling while reset is held must not disturb reset values.
    for (int i = 0; i < 4; i++) begin
      push = i[0]; pop = i[1]; flg_we = 1'b1; cond_valid = 1'b1;
      drive_flags(5'h1F);
      tick();
    end
    check("rst_flags", 8'(flags_out), 8'h00);
    check("rst_empty", 8'(stk_empty), 8'd1);
    check("rst_full", 8'(stk_full), 8'd0);
    check("rst_ready", 8'(cond_ready), 8'd1);
    check("rst_take_valid", 8'(take_valid), 8'd0);
    check("rst_take", 8'(take), 8'd0);
    check("rst_err", 8'(stk_err), 8'd0);
    push = 1'b0; pop = 1'b0; flg_we = 1'b0; cond_valid = 1'b0;
    rst = 1'b0;
    tick();

    // S0 C0 Z1 P1 V0
    set_flags(5'b00110);
    check("flags_load", 8'(flags_out), 8'h06);
    req(4'h0, 1'b1);
    req(4'h1, 1'b0);
    req(4'hE, 1'b1);
    req(4'hF, 1'b1);
    req(4'h9, 1'b1);
    req(4'h8, 1'b0);
    req(4'h3, 1'b1);

    set_flags(5'b10000);
    req(4'hA, 1'b0);
    req(4'hB, 1'b1);
    req(4'h4, 1'b1);
    req(4'h5, 1'b0);

    set_flags(5'b10001);
    req(4'hA, 1'b1);
    req(4'hC, 1'b1);
    req(4'h6, 1'b1);
    req(4'hD, 1'b0);

    set_flags(5'b00100);
    req(4'hD, 1'b1);
    req(4'hC, 1'b0);

    set_flags(5'b01000);
    req(4'h8, 1'b1);
    req(4'h2, 1'b1);

    // Save, clobber, restore.
    set_flags(5'h1F);
    do_op(1'b1, 1'b0, 1'b0, 5'h00);
    check("push1_empty", 8'(stk_empty), 8'd0);
    check("push1_flags", 8'(flags_out), 8'h1F);
    set_flags(5'h00);
    check("clobber_flags", 8'(flags_out), 8'h00);
    do_op(1'b0, 1'b1, 1'b0, 5'h00);
    check("restore_flags", 8'(flags_out), 8'h1F);
    check("restore_empty", 8'(stk_empty), 8'd1);
    check("restore_err", 8'(stk_err), 8'd0);

    // Fill with push+flg_we; the fifth push overflows.
    set_flags(5'h01);
    for (int i = 2; i <= 5; i++) begin
      do_op(1'b1, 1'b0, 1'b1, 5'(i));
      check("fill_flags", 8'(flags_out), 8'(i));
      check("fill_full", 8'(stk_full), 8'(i == 5));
      check("fill_err", 8'(stk_err), 8'd0);
    end
    do_op(1'b1, 1'b0, 1'b1, 5'h06);
    check("ovf_err", 8'(stk_err), 8'd1);
    check("ovf_full", 8'(stk_full), 8'd1);
    check("ovf_flags", 8'(flags_out), 8'h06);
    tick();
    check("ovf_err_pulse", 8'(stk_err), 8'd0);

    // Drain in LIFO order; flg_we loses to a legal pop.
    for (int i = 4; i >= 1; i--) begin
      do_op(1'b0, 1'b1, 1'b1, 5'h1A);
      check("drain_flags", 8'(flags_out), 8'(i));
      check("drain_empty", 8'(stk_empty), 8'(i == 1));
      check("drain_err", 8'(stk_err), 8'd0);
    end

    // Pop on empty: error, flags unchanged; then with flg_we applied.
    do_op(1'b0, 1'b1, 1'b0, 5'h00);
    check("udf_err", 8'(stk_err), 8'd1);
    check("udf_flags", 8'(flags_out), 8'h01);
    check("udf_empty", 8'(stk_empty), 8'd1);
    do_op(1'b0, 1'b1, 1'b1, 5'h0C);
    check("udf_we_flags", 8'(flags_out), 8'h0C);
    check("udf_we_err", 8'(stk_err), 8'd1);

    // Push and pop together: both ignored, flg_we applies.
    do_op(1'b1, 1'b1, 1'b1, 5'h13);
    check("pp_err", 8'(stk_err), 8'd1);
    check("pp_empty", 8'(stk_empty), 8'd1);
    check("pp_flags", 8'(flags_out), 8'h13);

    // cond_valid held for three edges: accepted on the first and third.
    set_flags(5'b00100);
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    tick();
    check("held_tv0", 8'(take_valid), 8'd1);
    check("held_rdy0", 8'(cond_ready), 8'd0);
    tick();
    check("held_tv1", 8'(take_valid), 8'd0);
    check("held_rdy1", 8'(cond_ready), 8'd1);
    check("held_take_hold", 8'(take), 8'd1);
    tick();
    check("held_tv2", 8'(take_valid), 8'd1);
    cond_valid = 1'b0;
    tick();
    check("held_tv3", 8'(take_valid), 8'd0);

    // Request accepted on the same edge as a flag load sees the old F.
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    flg_we     = 1'b1;
    drive_flags(5'b00000);
    exp_q.push_back(1'b1);
    tick();
    cond_valid = 1'b0;
    flg_we     = 1'b0;
    check("same_edge_flags", 8'(flags_out), 8'h00);
    tick();
    req(4'h0, 1'b0);

    // Reset arriving with a pending request discards it.
    cond_valid = 1'b1;
    cond_code  = 4'hF;
    rst        = 1'b1;
    tick();
    tick();
    cond_valid = 1'b0;
    rst        = 1'b0;
    check("rst_req_tv", 8'(take_valid), 8'd0);
    check("rst_req_take", 8'(take), 8'd0);
    tick();
    check("rst_req_tv2", 8'(take_valid), 8'd0);
    check("rst_req_ready", 8'(cond_ready), 8'd1);

    tick();
    tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
